// File: rtl/core_mem_axil_bridge_if.sv
// rtl/core_mem_axil_bridge_if.sv - core memory port: request from core, rdata/hit back
interface core_mem_if #(
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32
);
  logic [AddrWidth-1:0]   addr;
  logic                   wren;
  logic [DataWidth-1:0]   wdata;
  logic [DataWidth/8-1:0] wmask;
  logic                   rden;
  logic [DataWidth-1:0]   rdata;
  logic                   hit;

  modport mem (
    input  addr, wren, wdata, wmask, rden,
    output rdata, hit
  );

  modport core (
    output addr, wren, wdata, wmask, rden,
    input  rdata, hit
  );
endinterface

// File: rtl/core_mem_axil_bridge.sv
// rtl/core_mem_axil_bridge.sv - one core memory request -> one AXI4-Lite transaction
module core_mem_axil_bridge #(
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  core_mem_if.mem                mem,
  output logic [AddrWidth-1:0]   m_awaddr_o,
  output logic                   m_awvalid_o,
  input  logic                   m_awready_i,
  output logic [DataWidth-1:0]   m_wdata_o,
  output logic [DataWidth/8-1:0] m_wstrb_o,
  output logic                   m_wvalid_o,
  input  logic                   m_wready_i,
  input  logic [1:0]             m_bresp_i,
  input  logic                   m_bvalid_i,
  output logic                   m_bready_o,
  output logic [AddrWidth-1:0]   m_araddr_o,
  output logic                   m_arvalid_o,
  input  logic                   m_arready_i,
  input  logic [DataWidth-1:0]   m_rdata_i,
  input  logic [1:0]             m_rresp_i,
  input  logic                   m_rvalid_i,
  output logic                   m_rready_o,
  output logic                   err_o
);

  localparam int StrbWidth = DataWidth / 8;
  localparam int OffBits   = $clog2(StrbWidth);
  localparam logic [AddrWidth-1:0] AlignMask =
    ~((AddrWidth'(1) << OffBits) - AddrWidth'(1));

  typedef enum logic [2:0] {
    IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE
  } state_t;

  state_t state, state_next;

  logic [AddrWidth-1:0] addr_q;
  logic [DataWidth-1:0] wdata_q;
  logic [StrbWidth-1:0] wstrb_q;
  logic [DataWidth-1:0] rdata_q;
  logic                 aw_done;
  logic                 w_done;
  logic                 err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (mem.wren) begin
          state_next = WR_REQ;
        end else if (mem.rden) begin
          state_next = RD_ADDR;
        end
      end
      RD_ADDR: if (m_arready_i) state_next = RD_DATA;
      RD_DATA: if (m_rvalid_i)  state_next = DONE;
      // AW and W may complete in either order or together
      WR_REQ: begin
        if ((aw_done || m_awready_i) && (w_done || m_wready_i)) begin
          state_next = WR_RESP;
        end
      end
      WR_RESP: if (m_bvalid_i) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (state == IDLE) begin
        if (mem.wren) begin
          addr_q  <= mem.addr & AlignMask;
          wdata_q <= mem.wdata;
          wstrb_q <= mem.wmask;
          aw_done <= 1'b0;
          w_done  <= 1'b0;
        end else if (mem.rden) begin
          addr_q <= mem.addr & AlignMask;
        end
      end
      if (state == WR_REQ) begin
        if (m_awready_i) aw_done <= 1'b1;
        if (m_wready_i)  w_done  <= 1'b1;
      end
      if (state == RD_DATA && m_rvalid_i) begin
        rdata_q <= m_rdata_i;
        if (m_rresp_i != 2'b00) err_q <= 1'b1;
      end
      if (state == WR_RESP && m_bvalid_i && m_bresp_i != 2'b00) begin
        err_q <= 1'b1;
      end
    end
  end

  assign m_awaddr_o  = addr_q;
  assign m_araddr_o  = addr_q;
  assign m_wdata_o   = wdata_q;
  assign m_wstrb_o   = wstrb_q;
  assign m_awvalid_o = (state == WR_REQ) && !aw_done;
  assign m_wvalid_o  = (state == WR_REQ) && !w_done;
  assign m_bready_o  = (state == WR_RESP);
  assign m_arvalid_o = (state == RD_ADDR);
  assign m_rready_o  = (state == RD_DATA);
  assign err_o       = err_q;
  assign mem.rdata   = rdata_q;
  assign mem.hit     = (state == DONE);

endmodule

// File: tb/tb_core_mem_axil_bridge.sv
// tb/tb_core_mem_axil_bridge.sv - scoreboard bench with AXI-Lite slave and memory reference model
module tb_core_mem_axil_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m_awaddr;
  logic        m_awvalid;
  logic        m_awready;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wvalid;
  logic        m_wready;
  logic [1:0]  m_bresp;
  logic        m_bvalid;
  logic        m_bready;
  logic [31:0] m_araddr;
  logic        m_arvalid;
  logic        m_arready;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rvalid;
  logic        m_rready;
  logic        err;

  core_mem_if #(.AddrWidth(32), .DataWidth(32)) mem_bus ();

  core_mem_axil_bridge #(.AddrWidth(32), .DataWidth(32)) dut (
    .clk_i(clk), .rst_i(rst), .mem(mem_bus.mem),
    .m_awaddr_o(m_awaddr), .m_awvalid_o(m_awvalid), .m_awready_i(m_awready),
    .m_wdata_o(m_wdata), .m_wstrb_o(m_wstrb), .m_wvalid_o(m_wvalid), .m_wready_i(m_wready),
    .m_bresp_i(m_bresp), .m_bvalid_i(m_bvalid), .m_bready_o(m_bready),
    .m_araddr_o(m_araddr), .m_arvalid_o(m_arvalid), .m_arready_i(m_arready),
    .m_rdata_i(m_rdata), .m_rresp_i(m_rresp), .m_rvalid_i(m_rvalid), .m_rready_o(m_rready),
    .err_o(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  typedef struct {
    logic        is_rd;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ref_mem   [logic [31:0]];
  logic [31:0] slave_mem [logic [31:0]];
  logic [31:0] last_rdata = '0;
  logic        exp_err = 1'b0;
  int          reads_issued = 0;

  // Per-transaction slave behaviour; only one transaction is ever in flight
  int          cfg_ar = 0, cfg_r = 0, cfg_aw = 0, cfg_w = 0, cfg_b = 0;
  logic [1:0]  cfg_resp = 2'b00;

  function automatic logic [31:0] rd_ref(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  function automatic logic [31:0] rd_slave(input logic [31:0] a);
    return slave_mem.exists(a) ? slave_mem[a] : 32'h0;
  endfunction

  // AXI-Lite slave: decides its inputs at each falling edge for the next rising edge
  int          ar_hs = 0;
  initial begin
    logic        ar_act, aw_act, w_act, rd_pend, aw_got, w_got;
    int          ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    logic [31:0] ar_seen, aw_seen, w_seen, rd_addr, wa, wd, nv;
    logic [3:0]  ws;
    ar_act = 0; aw_act = 0; w_act = 0; rd_pend = 0; aw_got = 0; w_got = 0;
    ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    ar_seen = 0; aw_seen = 0; w_seen = 0; rd_addr = 0; wa = 0; wd = 0; ws = 0;
    m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0;
    m_arready = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0;
    forever begin
      @(negedge clk);
      m_arready = 0; m_rvalid = 0; m_awready = 0; m_wready = 0; m_bvalid = 0;
      if (rst) begin
        ar_act = 0; aw_act = 0; w_act = 0; rd_pend = 0; aw_got = 0; w_got = 0;
        continue;
      end
      if (rd_pend && m_rready) begin
        if (r_cnt == 0) begin
          m_rvalid = 1; m_rdata = rd_slave(rd_addr); m_rresp = cfg_resp; rd_pend = 0;
        end else r_cnt--;
      end
      if (aw_got && w_got && m_bready) begin
        if (b_cnt == 0) begin
          m_bvalid = 1; m_bresp = cfg_resp;
          nv = rd_slave(wa);
          for (int i = 0; i < 4; i++) if (ws[i]) nv[8*i +: 8] = wd[8*i +: 8];
          slave_mem[wa] = nv;
          aw_got = 0; w_got = 0;
        end else b_cnt--;
      end
      if (ar_act) begin
        check("ar_valid_held", 64'(m_arvalid), 64'(1));
        check("ar_addr_stable", 64'(m_araddr), 64'(ar_seen));
        if (!m_arvalid) ar_act = 0;
      end
      if (m_arvalid) begin
        if (!ar_act) begin ar_act = 1; ar_cnt = cfg_ar; ar_seen = m_araddr; end
        if (ar_cnt == 0) begin
          m_arready = 1; rd_pend = 1; rd_addr = m_araddr; r_cnt = cfg_r; ar_act = 0; ar_hs++;
        end else ar_cnt--;
      end
      if (aw_act) begin
        check("aw_valid_held", 64'(m_awvalid), 64'(1));
        check("aw_addr_stable", 64'(m_awaddr), 64'(aw_seen));
        if (!m_awvalid) aw_act = 0;
      end
      if (m_awvalid) begin
        if (!aw_act) begin aw_act = 1; aw_cnt = cfg_aw; aw_seen = m_awaddr; end
        if (aw_cnt == 0) begin
          m_awready = 1; aw_got = 1; wa = m_awaddr; aw_act = 0;
          if (w_got) b_cnt = cfg_b;
        end else aw_cnt--;
      end
      if (w_act) begin
        check("w_valid_held", 64'(m_wvalid), 64'(1));
        check("w_data_stable", 64'(m_wdata), 64'(w_seen));
        if (!m_wvalid) w_act = 0;
      end
      if (m_wvalid) begin
        if (!w_act) begin w_act = 1; w_cnt = cfg_w; w_seen = m_wdata; end
        if (w_cnt == 0) begin
          m_wready = 1; w_got = 1; wd = m_wdata; ws = m_wstrb; w_act = 0;
          if (aw_got) b_cnt = cfg_b;
        end else w_cnt--;
      end
    end
  end

  // Monitor: every hit retires the oldest expected completion
  always @(negedge clk) begin
    if (!rst && mem_bus.hit) begin
      if (sb.size() == 0) begin
        check("unexpected_hit", 64'(mem_bus.hit), 64'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        check(e.is_rd ? "read_rdata" : "rdata_hold", 64'(mem_bus.rdata), 64'(e.rdata));
        check("err_flag", 64'(err), 64'(e.err));
      end
    end
  end

  task automatic do_txn(input logic wr, input logic rd, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] mask,
                        input int ar, input int r, input int aw, input int w, input int b,
                        input logic [1:0] resp);
    logic [31:0] al, nv;
    exp_t        e;
    int          lat, exp_lat;
    logic        done;
    cfg_ar = ar; cfg_r = r; cfg_aw = aw; cfg_w = w; cfg_b = b; cfg_resp = resp;
    al = addr & ~32'h3;
    if (wr) begin
      nv = rd_ref(al);
      for (int i = 0; i < 4; i++) if (mask[i]) nv[8*i +: 8] = data[8*i +: 8];
      ref_mem[al] = nv;
      e.is_rd = 0;
      exp_lat = 3 + ((aw > w) ? aw : w) + b;
    end else begin
      reads_issued++;
      last_rdata = rd_ref(al);
      e.is_rd = 1;
      exp_lat = 3 + ar + r;
    end
    e.rdata = last_rdata;
    if (resp != 2'b00) exp_err = 1'b1;
    e.err = exp_err;
    sb.push_back(e);
    mem_bus.addr = addr; mem_bus.wdata = data; mem_bus.wmask = mask;
    mem_bus.wren = wr; mem_bus.rden = rd;
    lat = 0; done = 0;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        if (wr) begin
          check("aw_valid_c1", 64'(m_awvalid), 64'(1));
          check("w_valid_c1", 64'(m_wvalid), 64'(1));
          check("awaddr", 64'(m_awaddr), 64'(al));
          check("wdata", 64'(m_wdata), 64'(data));
          check("wstrb", 64'(m_wstrb), 64'(mask));
          check("no_ar_on_write", 64'(m_arvalid), 64'(0));
        end else begin
          check("ar_valid_c1", 64'(m_arvalid), 64'(1));
          check("araddr", 64'(m_araddr), 64'(al));
          check("no_aw_on_read", 64'(m_awvalid), 64'(0));
        end
      end
      if (mem_bus.hit) done = 1;
    end
    check("latency", 64'(lat), 64'(exp_lat));
    mem_bus.wren = 0; mem_bus.rden = 0;
    mem_bus.addr = $urandom; mem_bus.wdata = $urandom; mem_bus.wmask = 4'($urandom);
    @(negedge clk);
    check("hit_one_cycle", 64'(mem_bus.hit), 64'(0));
  endtask

  initial begin
    logic wr, rd;
    logic [1:0] resp;
    rst = 1;
    mem_bus.addr = 0; mem_bus.wdata = 0; mem_bus.wmask = 0;
    mem_bus.wren = 0; mem_bus.rden = 0;
    repeat (3) @(negedge clk);
    check("rst_hit", 64'(mem_bus.hit), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    check("rst_valids", 64'({m_awvalid, m_wvalid, m_arvalid}), 64'(0));
    check("rst_readies", 64'({m_bready, m_rready}), 64'(0));
    check("rst_rdata", 64'(mem_bus.rdata), 64'(0));
    check("rst_addr_data", 64'({m_awaddr, m_wdata}), 64'(0));
    check("rst_strb", 64'(m_wstrb), 64'(0));
    rst = 0;
    @(negedge clk);

    ref_mem[32'h1004] = 32'hDEAD_BEEF;
    slave_mem[32'h1004] = 32'hDEAD_BEEF;
    do_txn(0, 1, 32'h0000_1006, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00);
    do_txn(1, 0, 32'h0000_2000, 32'h1234_5678, 4'b0011, 0, 0, 0, 2, 1, 2'b00);
    do_txn(0, 1, 32'h0000_2000, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00);
    do_txn(1, 1, 32'h0000_2002, 32'hA5A5_C3C3, 4'b1100, 0, 0, 1, 0, 0, 2'b00);
    do_txn(0, 1, 32'h0000_2001, 32'h0, 4'h0, 5, 0, 0, 0, 0, 2'b00);
    do_txn(0, 1, 32'h0000_1004, 32'h0, 4'h0, 0, 1, 0, 0, 0, 2'b10);
    do_txn(1, 0, 32'h0000_1008, 32'h0BAD_F00D, 4'hF, 0, 0, 0, 0, 0, 2'b00);
    do_txn(0, 1, 32'h0000_1008, 32'h0, 4'h0, 1, 1, 0, 0, 0, 2'b00);

    for (int n = 0; n < 150; n++) begin
      wr = 1'($urandom_range(0, 1));
      rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      resp = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(2, 3)) : 2'b00;
      do_txn(wr, rd, 32'h3000 + 32'($urandom_range(0, 63)), $urandom, 4'($urandom),
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 3), resp);
    end

    // Abandon a read while it waits for data
    cfg_ar = 0; cfg_r = 6; cfg_resp = 2'b00;
    reads_issued++;
    mem_bus.addr = 32'h1004; mem_bus.rden = 1;
    repeat (2) @(negedge clk);
    check("rready_before_rst", 64'(m_rready), 64'(1));
    rst = 1;
    @(negedge clk);
    check("rst_mid_rready", 64'(m_rready), 64'(0));
    check("rst_mid_hit", 64'(mem_bus.hit), 64'(0));
    check("rst_mid_rdata", 64'(mem_bus.rdata), 64'(0));
    check("rst_mid_err", 64'(err), 64'(0));
    check("rst_mid_arvalid", 64'(m_arvalid), 64'(0));
    rst = 0; mem_bus.rden = 0;
    exp_err = 1'b0; last_rdata = '0;
    @(negedge clk);
    do_txn(0, 1, 32'h0000_1004, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00);

    check("ar_handshakes", 64'(ar_hs), 64'(reads_issued));
    check("sb_drained", 64'(sb.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
